buf_port_arbiter: RTL and testbench
===================================

# buf_port_arbiter

Round-robin arbiter that shares one single-port scratch buffer among N_REQ requesters, such as the convolution engine's input, weight and result ports, a host loader and a readback DMA. It grants at most one command per cycle and registers that command onto the buffer pins. It tags each read and routes the returned data back to the issuing requester after the buffer's fixed read latency. An optional lock lets one requester keep the port for a burst, for example a full K_SIZE×K_SIZE window load.

## Interface
- N_REQ, 3, number of requesters (≥1)
- ADDR_W, 16, buffer address width
- DATA_W, 32, buffer data width
- RD_LAT, 2, cycles from the cycle mem_cs/mem_ren are driven to the cycle mem_dout is valid (≥1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_cs  in  N_REQ  per-requester request, active-high
- req_wen  in  N_REQ  per-requester write enable, active-low (1 = read)
- req_lock  in  N_REQ  hold the grant after this command
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W]
- req_din  in  N_REQ*DATA_W  packed write data, packed the same way
- gnt  out  N_REQ  one-hot combinational grant; command accepted at an edge where req_cs[i]&gnt[i]
- rvalid  out  N_REQ  one-hot read-data-valid
- rdata  out  DATA_W  read data, shared by all requesters; meaningful only with rvalid
- mem_cs  out  1  buffer chip select, active-high
- mem_ren  out  1  buffer read enable, active-low
- mem_wen  out  1  buffer write enable, active-low
- mem_addr  out  ADDR_W  buffer address
- mem_din  out  DATA_W  buffer write data
- mem_dout  in  DATA_W  buffer read data

## Operation
- **Reset values:** gnt=0 (forced 0 while rstn low); rvalid=0; mem_cs=0, mem_ren=1, mem_wen=1; mem_addr=0, mem_din=0; rr_ptr=0; lock_owner invalid; tag pipeline cleared.
- **Arbitration (combinational):**
  - If a lock owner is valid and req_cs[owner]=1, gnt = that owner only.
  - Otherwise scan from rr_ptr upward, wrapping N_REQ-1→0, and grant the first i with req_cs[i]=1.
  - No request → gnt=0.
- **On an accept of requester i:**
  - rr_ptr <= (i+1) mod N_REQ. rr_ptr does not advance on idle cycles.
  - Next cycle: mem_cs=1 and mem_addr = req_addr[i].
  - Write (req_wen[i]=0): mem_wen=0, mem_ren=1, mem_din = req_din[i].
  - Read (req_wen[i]=1): mem_ren=0, mem_wen=1; mem_din holds its previous value.
  - lock_owner <= i if req_lock[i]=1, else lock_owner invalid.
- **Lock release:** a locked owner that drops req_cs releases the lock. The same cycle is arbitrated normally from rr_ptr.
- **No accept:** next cycle mem_cs=0, mem_ren=1, mem_wen=1; mem_addr and mem_din hold.
- **Read return:**
  - Each accepted read pushes {valid, id=i} into an RD_LAT+1-deep shift pipeline.
  - When that entry reaches the end, rvalid[id]=1 for exactly one cycle, with rdata = mem_dout (combinational pass-through).
  - Writes push valid=0.
- **Ordering:** commands execute and reads return in acceptance order. One command per cycle; back-to-back reads give back-to-back rvalid pulses.
- **Withdrawn requests:** a requester may drop or change req_cs, req_addr or req_din while ungranted, with no side effect. A command counts only on an accept edge.
- **N_REQ=1:** gnt[0] = req_cs[0]; rr_ptr stays 0.
- **Reset mid-operation:** in-flight reads are discarded. No rvalid after rstn rises until a new read is accepted.

## Timing
- Cycle C0: req_cs[i]=1 and gnt[i]=1 combinationally; accepted at the end of C0.
- C1: command on mem_* pins.
- C1+RD_LAT: rvalid[i]=1 and rdata valid. Default RD_LAT=2 → rvalid in C3.
- Grant latency: 0 cycles when the requester is uncontested.
- Worst case without locks: N_REQ-1 cycles of waiting.
- Full throughput: 1 command/cycle with continuous requests.
- All outputs except gnt and rdata are registered.

## Test plan
- Reset values: hold rstn low with req_cs=3'b111 → gnt=0, rvalid=0, mem_cs=0, mem_ren=1, mem_wen=1; release → gnt=3'b001.
- Single write then read: req 1 writes 0x0000_00A5 to addr 0x0010 in C0, then reads 0x0010.
  - Write: C1 mem_cs=1, mem_wen=0.
  - Read: rvalid=3'b010 exactly RD_LAT+1 cycles after the read accept, rdata=0x0000_00A5.
- Round-robin fairness: all three requesters continuously reading distinct addresses → grants 0,1,2,0,1,2…; each rvalid carries its own address's data.
- Wrap and idle: grant to req 2, two idle cycles, then req 0 and req 2 request together → req 0 granted first (rr_ptr wrapped to 0); mem_cs=0 during the idle cycles.
- Lock burst: req 0 issues 9 reads with req_lock=1 while req 1 requests continuously.
  - Req 1 is blocked for all 9 accepts.
  - When req 0 drops req_cs, req 1 is granted in the same cycle.
- Reset mid-flight: assert rstn for one cycle one cycle after a read accept → no rvalid ever appears for that read; mem outputs return to reset values.

Source files
------------

// File: rtl/buf_port_arbiter.sv
// ---------------------------------------------------------------------------
// buf_port_arbiter
//
// This block shares one single-port scratch buffer among N_REQ requesters.
// It uses round-robin arbitration and grants at most one command per cycle.
// The granted command is registered onto the buffer pins in the next cycle.
// Each accepted read is tagged with its requester id. The tag travels down
// a shift pipeline that matches the buffer read latency, so the returned
// data can be routed back to the requester that issued the read.
// A requester that sets req_lock keeps the port for the next command. This
// allows an uninterrupted burst.
//
// Ports:
//   clk, rstn         clock; asynchronous active-low reset
//   req_cs[N_REQ]     per-requester request (active-high)
//   req_wen[N_REQ]    per-requester write enable (active-low, 1 = read)
//   req_lock[N_REQ]   keep the grant after this command
//   req_addr, req_din packed per-requester address / write data
//   gnt[N_REQ]        one-hot combinational grant
//   rvalid[N_REQ]     one-hot read-data-valid
//   rdata             read data, shared by all requesters (mem_dout)
//   mem_cs/ren/wen    buffer strobes (cs active-high, ren/wen active-low)
//   mem_addr/din      buffer address / write data
//   mem_dout          buffer read data, valid RD_LAT cycles after the command
// ---------------------------------------------------------------------------
module buf_port_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_cs,
  input  logic [N_REQ-1:0]          req_wen,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_din,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_cs,
  output logic                      mem_ren,
  output logic                      mem_wen,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_dout
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  id_t               rr_ptr_q, rr_ptr_d;
  logic              lock_vld_q, lock_vld_d;
  id_t               lock_id_q, lock_id_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  tag_t              tag_q [RD_LAT+1];
  tag_t              tag_d;

  logic              gnt_any;
  id_t               gnt_idx;
  id_t               cand;

  // Arbitration. A valid lock owner that is still requesting wins outright.
  // Otherwise the first active requester at or after rr_ptr wins, with the
  // search wrapping around from N_REQ-1 to 0.
  // NOTE: every variable written here gets a default value first. Then no
  // path leaves a variable unassigned, so no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (lock_vld_q && req_cs[lock_id_q]) begin
      gnt_any = 1'b1;
      gnt_idx = lock_id_q;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = id_t'((int'(rr_ptr_q) + k) % N_REQ);
        if (!gnt_any && req_cs[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    // While reset is asserted, no grant is issued and no command is accepted.
    if (!rstn) gnt_any = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // Next-state logic for the pins, the pointer and the lock. When no command
  // is accepted, the lock is cleared. The owner can only lose the grant by
  // dropping req_cs, and dropping req_cs is what releases the lock.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = 1'b0;
    lock_id_d  = lock_id_q;
    mem_cs_d   = 1'b0;
    mem_ren_d  = 1'b1;
    mem_wen_d  = 1'b1;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    tag_d      = '{vld: 1'b0, id: gnt_idx};
    if (gnt_any) begin
      rr_ptr_d   = (int'(gnt_idx) == N_REQ - 1) ? '0 : id_t'(gnt_idx + 1'b1);
      lock_vld_d = req_lock[gnt_idx];
      lock_id_d  = gnt_idx;
      mem_cs_d   = 1'b1;
      mem_addr_d = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      if (!req_wen[gnt_idx]) begin
        mem_wen_d = 1'b0;
        mem_din_d = req_din[int'(gnt_idx)*DATA_W +: DATA_W];
      end else begin
        mem_ren_d = 1'b0;
        tag_d.vld = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the values from before the clock edge, so the result does not
  // depend on the order in which the simulator evaluates the processes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      mem_cs_q   <= 1'b0;
      mem_ren_q  <= 1'b1;
      mem_wen_q  <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      // NOTE: the tag pipeline is built from flops, not from a RAM, so it
      // is reset. Clearing it here drops reads that are in flight, which
      // stops any stale rvalid from appearing after reset.
      for (int k = 0; k <= RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      mem_cs_q   <= mem_cs_d;
      mem_ren_q  <= mem_ren_d;
      mem_wen_q  <= mem_wen_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      tag_q[0]   <= tag_d;
      for (int k = 1; k <= RD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // A tag pushed at the accept edge sits in stage 0 while its command is on
  // the pins. It therefore reaches stage RD_LAT in the same cycle that the
  // buffer drives the read data.
  always_comb begin
    rvalid = '0;
    if (tag_q[RD_LAT].vld) rvalid[tag_q[RD_LAT].id] = 1'b1;
  end

  assign rdata    = mem_dout;
  assign mem_cs   = mem_cs_q;
  assign mem_ren  = mem_ren_q;
  assign mem_wen  = mem_wen_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_buf_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buf_port_arbiter
//
// Testbench for buf_port_arbiter with N_REQ=3 and RD_LAT=2. A behavioural
// buffer model answers reads after RD_LAT cycles. An address that has never
// been written reads back as {16'hDEAD, addr}. Expected read returns are
// queued in issue order. A negedge monitor pops one entry for every rvalid
// pulse and compares it.
// ---------------------------------------------------------------------------
module tb_buf_port_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [N_REQ-1:0]        req_cs, req_wen, req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_din;
  logic [N_REQ-1:0]        gnt, rvalid;
  logic [DATA_W-1:0]       rdata, mem_din, mem_dout;
  logic                    mem_cs, mem_ren, mem_wen;
  logic [ADDR_W-1:0]       mem_addr;

  buf_port_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .req_cs(req_cs), .req_wen(req_wen),
    .req_lock(req_lock), .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_cs(mem_cs),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   rr_exp[6] = '{2, 0, 1, 2, 0, 1};

  function automatic logic [31:0] fill(input logic [15:0] a);
    return {16'hDEAD, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural buffer: the command is sampled at the edge that ends its pin
  // cycle, and the read data is presented RD_LAT cycles after the pin cycle.
  logic [31:0] mem_m [logic [15:0]];
  logic [31:0] dpipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_cs && !mem_wen) mem_m[mem_addr] = mem_din;
    if (mem_cs && !mem_ren)
      dpipe[0] <= mem_m.exists(mem_addr) ? mem_m[mem_addr] : fill(mem_addr);
    else
      dpipe[0] <= 32'h0;
    for (int k = 1; k < RD_LAT; k++) dpipe[k] <= dpipe[k-1];
  end

  assign mem_dout = dpipe[RD_LAT-1];

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rvalid !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=%b rdata=%h expected none at %0t",
                 rvalid, rdata, $time);
      end else begin
        mon_e = sb.pop_front();
        check("rvalid_id", 64'(rvalid), 64'(1) << mon_e.id);
        check("rdata", 64'(rdata), 64'(mon_e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic cs, input logic wen,
                         input logic lock, input logic [15:0] a,
                         input logic [31:0] d);
    req_cs[i]          = cs;
    req_wen[i]         = wen;
    req_lock[i]        = lock;
    req_addr[i*16 +: 16] = a;
    req_din[i*32 +: 32]  = d;
  endtask

  initial begin
    rstn     = 1'b0;
    req_cs   = '0;
    req_wen  = '1;
    req_lock = '0;
    req_addr = '0;
    req_din  = '0;

    // Reset values, with all requesters active
    repeat (3) @(posedge clk);
    #1 req_cs = 3'b111;
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_rvalid", 64'(rvalid), 64'h0);
    check("rst_mem_cs", 64'(mem_cs), 64'h0);
    check("rst_mem_ren", 64'(mem_ren), 64'h1);
    check("rst_mem_wen", 64'(mem_wen), 64'h1);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_din", 64'(mem_din), 64'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1 check("post_rst_gnt", 64'(gnt), 64'h1);
    req_cs = '0;                       // withdrawn before the edge
    step();
    @(negedge clk);
    check("withdrawn_no_cmd", 64'(mem_cs), 64'h0);

    // Requester 1 writes 0xA5 to 0x0010, then reads the same address back
    step();
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0000_00A5);
    @(negedge clk);
    check("wr_gnt", 64'(gnt), 64'h2);
    step();
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    check("wr_mem_cs", 64'(mem_cs), 64'h1);
    check("wr_mem_wen", 64'(mem_wen), 64'h0);
    check("wr_mem_ren", 64'(mem_ren), 64'h1);
    check("wr_mem_addr", 64'(mem_addr), 64'h10);
    check("wr_mem_din", 64'(mem_din), 64'hA5);
    check("rd_gnt", 64'(gnt), 64'h2);
    sb.push_back('{1, 32'h0000_00A5});
    step();
    req_cs = '0;
    @(negedge clk);
    check("rd_mem_ren", 64'(mem_ren), 64'h0);
    check("rd_mem_wen", 64'(mem_wen), 64'h1);
    check("rd_mem_din_hold", 64'(mem_din), 64'hA5);
    check("rd_rvalid_c1", 64'(rvalid), 64'h0);
    step();
    @(negedge clk);
    check("rd_rvalid_c2", 64'(rvalid), 64'h0);
    check("idle_mem_cs", 64'(mem_cs), 64'h0);
    step();
    @(negedge clk);
    check("rd_rvalid_c3", 64'(rvalid), 64'h2);

    // Round-robin: rr_ptr is now 2, all three requesters read continuously
    step();
    for (int i = 0; i < N_REQ; i++)
      set_req(i, 1'b1, 1'b1, 1'b0, 16'(16'h0100 + i * 4), 32'h0);
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      check("rr_gnt", 64'(gnt), 64'(1) << rr_exp[r]);
      sb.push_back('{rr_exp[r], fill(16'(16'h0100 + rr_exp[r] * 4))});
      step();
    end
    req_cs = '0;

    // Wrap and idle: grant requester 2, idle twice, then 0 and 2 together
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h0200, 32'h22);
    @(negedge clk);
    check("wrap_gnt2", 64'(gnt), 64'h4);
    step();
    req_cs = '0;
    @(negedge clk);
    check("idle1_gnt", 64'(gnt), 64'h0);
    step();
    @(negedge clk);
    check("idle1_mem_cs", 64'(mem_cs), 64'h0);
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h33);
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h0200, 32'h22);
    @(negedge clk);
    check("idle2_mem_cs", 64'(mem_cs), 64'h0);
    check("wrap_gnt0_first", 64'(gnt), 64'h1);
    step();
    req_cs[0] = 1'b0;
    @(negedge clk);
    check("wrap_gnt2_next", 64'(gnt), 64'h4);
    check("wrap_mem_addr", 64'(mem_addr), 64'h300);
    check("wrap_mem_din", 64'(mem_din), 64'h33);
    step();
    req_cs  = '0;
    req_wen = '1;

    // Lock burst: requester 0 locks for 9 reads while requester 1 contends
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0500, 32'h0);
    for (int k = 0; k < 9; k++) begin
      set_req(0, 1'b1, 1'b1, 1'b1, 16'(16'h0400 + k), 32'h0);
      @(negedge clk);
      check("lock_gnt", 64'(gnt), 64'h1);
      sb.push_back('{0, fill(16'(16'h0400 + k))});
      step();
    end
    set_req(0, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check("lock_release_gnt", 64'(gnt), 64'h2);
    sb.push_back('{1, fill(16'h0500)});
    step();
    req_cs = '0;

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'h0);

    // Reset mid-flight: a read is accepted, then reset pulses one cycle later
    step();
    set_req(2, 1'b1, 1'b1, 1'b0, 16'h0600, 32'h0);
    @(negedge clk);
    check("mf_gnt", 64'(gnt), 64'h4);
    step();
    req_cs = '0;
    step();
    rstn = 1'b0;
    @(negedge clk);
    check("mf_mem_cs", 64'(mem_cs), 64'h0);
    check("mf_mem_ren", 64'(mem_ren), 64'h1);
    check("mf_mem_wen", 64'(mem_wen), 64'h1);
    check("mf_mem_addr", 64'(mem_addr), 64'h0);
    check("mf_mem_din", 64'(mem_din), 64'h0);
    check("mf_rvalid", 64'(rvalid), 64'h0);
    step();
    rstn = 1'b1;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      check("mf_no_rvalid", 64'(rvalid), 64'h0);
    end
    check("final_sb_empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
